// File: rtl/cpu_core.sv
// Multi-cycle register CPU (FETCH/DECODE/EXEC|IMM), one request/ready read port; 3 cycles per instruction at zero wait.
// Backpressure: FETCH and IMM hold state, PC and mem_addr while mem_ready is low; mem_ready is ignored when mem_req is low.
module cpu_core #(
    parameter  int DATA_W     = 16,
    parameter  int REG_CNT    = 16,
    parameter  int ADDR_W     = 16,
    parameter  int RESET_ADDR = 50,
    localparam int RA         = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    output logic              halted,
    input  logic [RA-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_value
);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, IMM, HALT} state_t;

    state_t            state;
    logic [DATA_W-1:0] regs [REG_CNT];
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [ADDR_W-1:0] pc;
    logic              z_flag;
    logic              c_flag;

    logic [3:0]        op;
    logic [RA-1:0]     rd;
    logic [RA-1:0]     rs;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] imm_addr;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              unused_ir;

    assign op        = ir[DATA_W-1 -: 4];
    assign rd        = ir[DATA_W-5 -: RA];
    assign rs        = ir[DATA_W-5-RA -: RA];
    assign unused_ir = &{1'b0, ir};
    assign pc_inc    = pc + ADDR_W'(1);
    assign imm_addr  = ADDR_W'(mem_data);
    assign mem_addr  = pc;
    assign dbg_value = regs[dbg_addr];

    // MOV passes op2 through; flag writeback is suppressed for it in EXEC.
    always_comb begin
        alu_res = op2;
        alu_c   = c_flag;
        case (op)
            4'h3: {alu_c, alu_res} = {1'b0, op1} + {1'b0, op2};
            4'h4: {alu_c, alu_res} = {1'b0, op1} - {1'b0, op2};
            4'h5: begin alu_res = op1 & op2; alu_c = 1'b0; end
            4'h6: begin alu_res = op1 | op2; alu_c = 1'b0; end
            4'h7: begin alu_res = op1 ^ op2; alu_c = 1'b0; end
            4'h8: {alu_c, alu_res} = {op1, 1'b0};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= ADDR_W'(RESET_ADDR);
            ir      <= '0;
            op1     <= '0;
            op2     <= '0;
            z_flag  <= 1'b0;
            c_flag  <= 1'b0;
            mem_req <= 1'b0;
            halted  <= 1'b0;
            for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= FETCH;
                    mem_req <= 1'b1;
                end
                FETCH: begin
                    if (mem_ready) begin
                        ir      <= mem_data;
                        pc      <= pc_inc;
                        state   <= DECODE;
                        mem_req <= 1'b0;
                    end
                end
                DECODE: begin
                    op1 <= regs[rd];
                    op2 <= regs[rs];
                    case (op)
                        4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: state <= EXEC;
                        4'h1, 4'h9, 4'hA, 4'hB: begin
                            state   <= IMM;
                            mem_req <= 1'b1;
                        end
                        4'hF: begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end
                        default: begin
                            state   <= FETCH;
                            mem_req <= 1'b1;
                        end
                    endcase
                end
                EXEC: begin
                    regs[rd] <= alu_res;
                    if (op != 4'h2) begin
                        z_flag <= (alu_res == '0);
                        c_flag <= alu_c;
                    end
                    state   <= FETCH;
                    mem_req <= 1'b1;
                end
                IMM: begin
                    // mem_req stays high: the next FETCH request follows back-to-back.
                    if (mem_ready) begin
                        case (op)
                            4'h1: begin
                                regs[rd] <= mem_data;
                                pc       <= pc_inc;
                            end
                            4'h9:    pc <= imm_addr;
                            4'hA:    pc <= z_flag ? imm_addr : pc_inc;
                            4'hB:    pc <= c_flag ? imm_addr : pc_inc;
                            default: pc <= pc_inc;
                        endcase
                        state <= FETCH;
                    end
                end
                HALT: begin
                    halted  <= 1'b1;
                    mem_req <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: program words are written to a RAM model and every fetched address is pushed to an expected queue;
// the memory driver records the accepted addresses, which each test pops against the expected queue, then checks registers.
module tb_cpu_core;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int RA = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] mem_data = '0;
    logic          mem_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_req;
    logic          halted;
    logic [RA-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_value;

    logic [DW-1:0] mem [0:65535];
    logic [AW-1:0] exp_q [$];
    logic [AW-1:0] obs_q [$];
    int            cyc_q [$];
    int            hold_err;
    int            tests = 0;
    int            fails = 0;

    always #5 clk = ~clk;

    cpu_core #(.DATA_W(DW), .REG_CNT(16), .ADDR_W(AW), .RESET_ADDR(50)) dut (
        .clk(clk), .rst(rst), .mem_data(mem_data), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_req(mem_req), .halted(halted),
        .dbg_addr(dbg_addr), .dbg_value(dbg_value)
    );

    task automatic clear_prog();
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        exp_q.delete();
    endtask

    task automatic put(input logic [AW-1:0] a, input logic [DW-1:0] w);
        mem[a] = w;
        exp_q.push_back(a);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic peek(input int r, output logic [DW-1:0] v);
        dbg_addr = RA'(r);
        #1;
        v = dbg_value;
    endtask

    // Serves requests with wait_n low-ready cycles each; garbage on mem_data whenever not ready.
    task automatic run_mem(input int n_acc, input int wait_n, input bit noisy);
        int            wc = 0;
        int            cyc = 0;
        logic          waiting = 1'b0;
        logic [AW-1:0] last_addr = '0;
        obs_q.delete();
        cyc_q.delete();
        hold_err = 0;
        while (obs_q.size() < n_acc && cyc < 2000) begin
            @(negedge clk);
            if (waiting && (!mem_req || mem_addr != last_addr)) hold_err++;
            waiting = 1'b0;
            if (mem_req) begin
                if (wc >= wait_n) begin
                    mem_ready = 1'b1;
                    mem_data  = mem[mem_addr];
                    wc = 0;
                    obs_q.push_back(mem_addr);
                    cyc_q.push_back(cyc);
                end else begin
                    mem_ready = 1'b0;
                    mem_data  = DW'($urandom);
                    wc++;
                    waiting   = 1'b1;
                    last_addr = mem_addr;
                end
            end else begin
                mem_ready = noisy;
                mem_data  = DW'($urandom);
                wc = 0;
            end
            cyc++;
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        mem_data  = DW'($urandom);
    endtask

    task automatic test_reset();
        logic [DW-1:0] v;
        int bad = 0;
        rst = 1'b1;
        mem_ready = 1'b1;
        mem_data = 16'hDEAD;
        repeat (3) @(negedge clk);
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", mem_req); end
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b want 0", halted); end
        tests++; if (mem_addr !== 16'd50) begin fails++; $display("FAIL reset_addr: got %0d want 50", mem_addr); end
        for (int r = 0; r < 16; r++) begin
            peek(r, v);
            if (v !== '0) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL reset_regs: %0d nonzero registers, want 0", bad); end
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL idle_req: got %b want 0", mem_req); end
        @(posedge clk);
        #1;
        tests++; if (mem_req !== 1'b1 || mem_addr !== 16'd50) begin
            fails++; $display("FAIL first_fetch: req %b addr %0d, want req 1 addr 50", mem_req, mem_addr); end
        @(posedge clk);
        #1;
        tests++; if (mem_req !== 1'b1 || mem_addr !== 16'd50) begin
            fails++; $display("FAIL fetch_hold: req %b addr %0d, want req 1 addr 50", mem_req, mem_addr); end
    endtask

    task automatic test_imm_add(input int wait_n);
        logic [DW-1:0] v;
        int            er [3] = '{1, 2, 0};
        logic [DW-1:0] ev [3] = '{16'd8, 16'd3, 16'd0};
        int            exp_gap;
        clear_prog();
        put(16'd50, 16'h1100); put(16'd51, 16'h0005);
        put(16'd52, 16'h1200); put(16'd53, 16'h0003);
        put(16'd54, 16'h3120);
        put(16'd55, 16'hA000); put(16'd56, 16'h0100);
        put(16'd57, 16'hB000); put(16'd58, 16'h0200);
        put(16'd59, 16'hF000);
        do_reset();
        run_mem(exp_q.size(), wait_n, wait_n != 0);
        tests++; if (obs_q.size() != exp_q.size()) begin
            fails++; $display("FAIL imm_add_count(w%0d): got %0d want %0d", wait_n, obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests++; if (obs_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL imm_add_addr(w%0d)[%0d]: got %h want %h", wait_n, i, obs_q[i], exp_q[i]); end
        end
        exp_gap = 9 + 5 * wait_n;
        if (cyc_q.size() > 5) begin
            tests++; if (cyc_q[5] - cyc_q[0] != exp_gap) begin
                fails++; $display("FAIL imm_add_latency(w%0d): got %0d want %0d", wait_n, cyc_q[5] - cyc_q[0], exp_gap); end
        end
        tests++; if (hold_err != 0) begin fails++; $display("FAIL wait_hold(w%0d): got %0d moves want 0", wait_n, hold_err); end
        repeat (2) @(posedge clk);
        #1;
        tests++; if (halted !== 1'b1) begin fails++; $display("FAIL imm_add_halt(w%0d): got %b want 1", wait_n, halted); end
        for (int i = 0; i < 3; i++) begin
            peek(er[i], v);
            tests++; if (v !== ev[i]) begin fails++; $display("FAIL imm_add_r%0d(w%0d): got %h want %h", er[i], wait_n, v, ev[i]); end
        end
    endtask

    task automatic test_carry_zero();
        logic [DW-1:0] v;
        int            er [3] = '{1, 2, 3};
        logic [DW-1:0] ev [3] = '{16'h0000, 16'h0001, 16'h0002};
        clear_prog();
        put(16'd50, 16'h1100); put(16'd51, 16'hFFFF);
        put(16'd52, 16'h1200); put(16'd53, 16'h0001);
        put(16'd54, 16'h3120);
        put(16'd55, 16'hA000); put(16'd56, 16'h0080);
        put(16'h0080, 16'hB000); put(16'h0081, 16'h0090);
        put(16'h0090, 16'h1300); put(16'h0091, 16'h0001);
        put(16'h0092, 16'h3330);
        put(16'h0093, 16'hB000); put(16'h0094, 16'h0200);
        put(16'h0095, 16'hA000); put(16'h0096, 16'h0300);
        put(16'h0097, 16'hF000);
        do_reset();
        run_mem(exp_q.size(), 0, 1'b0);
        tests++; if (obs_q.size() != exp_q.size()) begin
            fails++; $display("FAIL cz_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests++; if (obs_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL cz_addr[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            peek(er[i], v);
            tests++; if (v !== ev[i]) begin fails++; $display("FAIL cz_r%0d: got %h want %h", er[i], v, ev[i]); end
        end
    endtask

    task automatic test_alu();
        logic [DW-1:0] v;
        int            er [7] = '{1, 2, 4, 5, 6, 7, 8};
        logic [DW-1:0] ev [7] = '{16'h00F0, 16'h1E78, 16'h0030, 16'h0FFC, 16'h0FCC, 16'hF1B4, 16'h1E78};
        logic [DW-1:0] prog [14] = '{16'h1100, 16'h00F0, 16'h1200, 16'h0F3C, 16'h2410, 16'h5420, 16'h2510,
                                     16'h6520, 16'h2610, 16'h7620, 16'h2710, 16'h4720, 16'hB000, 16'h0100};
        clear_prog();
        for (int i = 0; i < 14; i++) put(AW'(50 + i), prog[i]);
        put(16'h0100, 16'h2820); put(16'h0101, 16'hC123);
        put(16'h0102, 16'h8800); put(16'h0103, 16'h3220);
        put(16'h0104, 16'hF000);
        do_reset();
        run_mem(exp_q.size(), 1, 1'b1);
        tests++; if (obs_q.size() != exp_q.size()) begin
            fails++; $display("FAIL alu_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests++; if (obs_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL alu_addr[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            peek(er[i], v);
            tests++; if (v !== ev[i]) begin fails++; $display("FAIL alu_r%0d: got %h want %h", er[i], v, ev[i]); end
        end
    endtask

    task automatic test_halt_reset();
        logic [DW-1:0] v;
        int bad = 0;
        clear_prog();
        put(16'd50, 16'h1100); put(16'd51, 16'h0009); put(16'd52, 16'hF000);
        do_reset();
        run_mem(3, 0, 1'b0);
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (halted !== 1'b1 || mem_req !== 1'b0) bad++;
        end
        mem_ready = 1'b0;
        tests++; if (bad != 0) begin fails++; $display("FAIL halt_stuck: %0d bad cycles want 0", bad); end
        peek(1, v);
        tests++; if (v !== 16'h0009) begin fails++; $display("FAIL halt_r1: got %h want 0009", v); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_async_rst: got %b want 0", halted); end
        peek(1, v);
        tests++; if (v !== '0) begin fails++; $display("FAIL rst_r1: got %h want 0000", v); end
        @(negedge clk);
        rst = 1'b0;
        run_mem(1, 0, 1'b0);
        @(posedge clk);
        #1;
        tests++; if (mem_req !== 1'b1 || mem_addr !== 16'd51) begin
            fails++; $display("FAIL imm_wait: req %b addr %0d, want req 1 addr 51", mem_req, mem_addr); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (mem_req !== 1'b0 || mem_addr !== 16'd50) begin
            fails++; $display("FAIL mid_imm_rst: req %b addr %0d, want req 0 addr 50", mem_req, mem_addr); end
        @(negedge clk);
        rst = 1'b0;
        run_mem(3, 0, 1'b0);
        tests++; if (obs_q.size() != 3) begin fails++; $display("FAIL restart_count: got %0d want 3", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests++; if (obs_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL restart_addr[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        repeat (2) @(posedge clk);
        #1;
        peek(1, v);
        tests++; if (v !== 16'h0009) begin fails++; $display("FAIL restart_r1: got %h want 0009", v); end
    endtask

    task automatic test_wrap();
        clear_prog();
        put(16'd50, 16'h9000); put(16'd51, 16'hFFFF);
        put(16'hFFFF, 16'h0000);
        put(16'h0000, 16'hF000);
        do_reset();
        run_mem(exp_q.size(), 0, 1'b0);
        tests++; if (obs_q.size() != exp_q.size()) begin
            fails++; $display("FAIL wrap_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests++; if (obs_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        repeat (2) @(posedge clk);
        #1;
        tests++; if (halted !== 1'b1) begin fails++; $display("FAIL wrap_halt: got %b want 1", halted); end
    endtask

    initial begin
        test_reset();
        test_imm_add(0);
        test_imm_add(3);
        test_carry_zero();
        test_alu();
        test_halt_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/cpu_core.md
Name: cpu_core

Overview:
- Parametrised successor to the team's first CPU: configurable data width, register count, address width and reset vector.
- Adds what the first generation lacks: immediate loads, Z/C flags, unconditional and conditional jumps, halt, and a reset port.
- Reads instructions and operands through a single request/ready memory read port. The address counter becomes a loadable program counter.
- Sits between the instruction/data RAM model and the top level.

Parameters:
DATA_W, 16, datapath and instruction width; must be >= 4 + 2*clog2(REG_CNT)
REG_CNT, 16, number of general registers (power of two); RA = clog2(REG_CNT)
ADDR_W, 16, program counter / memory address width
RESET_ADDR, 50, PC value after reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
mem_data  in  DATA_W  read data from RAM, valid when mem_ready=1
mem_ready  in  1  RAM has data for the current request
mem_addr  out  ADDR_W  read address (= PC)
mem_req  out  1  read request
halted  out  1  core executed HLT
dbg_addr  in  RA  debug register select
dbg_value  out  DATA_W  combinational read of register dbg_addr

Behaviour:
- Reset (async, any time, including mid-fetch): PC=RESET_ADDR, all registers=0, Z=C=0, IR=0, state=IDLE, mem_req=0, halted=0.
- Instruction fields: op=[DATA_W-1:DATA_W-4], rd=next RA bits, rs=next RA bits, remaining LSBs ignored.
- Opcodes:
  - 0 NOP
  - 1 LDI rd,#imm (imm is the next word)
  - 2 MOV rd,rs
  - 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR: all rd = rd op rs
  - 8 SHL rd (shift left 1)
  - 9 JMP #addr, A JZ #addr, B JC #addr (addr is the next word, low ADDR_W bits)
  - F HLT
  - C..E reserved, executed as NOP.
- FSM states: IDLE, FETCH, DECODE, EXEC, IMM, HALT.
- IDLE: mem_req=0 -> FETCH next cycle.
- FETCH: mem_req=1, mem_addr=PC. Stay while mem_ready=0. On mem_ready=1: IR<=mem_data, PC<=PC+1 -> DECODE.
- DECODE: op1<=reg[rd], op2<=reg[rs]. Next state:
  - ops 2..8 -> EXEC
  - ops 1, 9..B -> IMM
  - F -> HALT
  - otherwise -> FETCH
- EXEC: reg[rd]<=result -> FETCH. Flag updates (MOV leaves flags unchanged):
  - ADD: C = carry out of bit DATA_W-1.
  - SUB: C = borrow (op1 < op2 unsigned).
  - Logic ops: C=0.
  - SHL: C = old MSB.
  - Z = (result==0) for ops 3..8.
- IMM: mem_req=1, mem_addr=PC. Stay while mem_ready=0. On mem_ready=1:
  - LDI: reg[rd]<=mem_data, PC<=PC+1.
  - JMP: PC<=mem_data.
  - JZ/JC: PC<=mem_data if the flag is set, else PC<=PC+1.
  - Then -> FETCH. LDI and jumps do not alter flags.
- HALT: halted=1, mem_req=0. Terminal until rst.
- mem_ready is ignored when mem_req=0. mem_data is sampled only in the cycle where mem_req=1 and mem_ready=1.
- mem_addr always drives PC; it is meaningful only while mem_req=1.
- PC wraps modulo 2^ADDR_W (PC=all-ones +1 -> 0).
- All arithmetic is modulo 2^DATA_W.
- rd==rs is legal: both operands are the old value.
- Latency at zero wait-states:
  - ALU/MOV: FETCH+DECODE+EXEC = 3 cycles.
  - LDI/jumps: FETCH+DECODE+IMM = 3 cycles.
  - Each cycle with mem_ready low adds one cycle.
- First fetch request occurs 1 cycle after rst deasserts.
- The register file has one write port and three read ports (rd, rs, dbg). dbg_value reflects a write from the cycle after the write edge.

Test Plan:
- Reset/vector: hold rst, release -> mem_req=0 one cycle, then mem_req=1 with mem_addr=50. All dbg reads return 0.
- Immediate+add (DATA_W=16, memory ready every cycle), program at 50: 0x1100, 0x0005, 0x1200, 0x0003, 0x3120 -> r1=8, r2=3, Z=0, C=0. The instruction at 55 is fetched 9 cycles after the first fetch.
- Carry/zero:
  - LDI r1,#0xFFFF; LDI r2,#1; ADD r1,r2 -> r1=0, Z=1, C=1.
  - Then JZ #0x0080 -> next mem_addr=0x0080.
  - JC with C=0 -> PC falls through to the word after the address.
- Wait states: mem_ready low for 3 cycles on every request, with mem_data = garbage while low -> same final registers as the immediate+add test. State held, no PC advance while waiting.
- HLT and async reset: HLT -> halted=1, mem_req=0 permanently. Assert rst mid-IMM (between clock edges) -> outputs reset immediately, execution restarts at 50.
- Wrap: JMP #0xFFFF, NOP at 0xFFFF -> next fetch address 0x0000.
